// File: rtl/fp32_div_scheduler_pkg.sv
// Shared types and constants for the FP32 divider scheduler.
// Holds the FSM state type, the timeout quotient and a width helper.
package fp32_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp32_div_scheduler_arb.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_arbiter
    import fp32_div_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_onehot_o,
    output logic [IW-1:0] grant_idx_o
);

    always_comb begin
        logic [IW-1:0] j;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        j              = '0;
        // Walk from farthest to nearest so the closest hit above ptr_i wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                grant_onehot_o    = '0;
                grant_onehot_o[j] = 1'b1;
                grant_idx_o       = j;
            end
        end
    end

endmodule

// File: rtl/fp32_div_scheduler.sv
// Shares one FP32 divider among NUM_REQ requesters: round-robin accept,
// one-cycle issue pulse, wait for a fresh done edge (or time out), one-cycle reply.
module fp32_div_scheduler
    import fp32_div_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          div_valid_o,
    output logic [DATA_WIDTH-1:0]         div_a_o,
    output logic [DATA_WIDTH-1:0]         div_b_o,
    input  logic [DATA_WIDTH-1:0]         div_result_i,
    input  logic                          div_done_i,
    output logic                          busy_o,
    output sched_state_e                  dbg_state_o
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam int CW = clog2_min1(TIMEOUT);

    sched_state_e          state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    grant_onehot;
    logic [IW-1:0]         grant_idx;
    logic                  accept;
    logic                  done_rise;
    logic                  timeout_hit;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i          (req_valid_i),
        .ptr_i          (rr_ptr_q),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx)
    );

    // Handshake: a requester holds valid and operands until it sees its ready
    // bit; ready is offered only in IDLE, so at most one transfer per job.
    assign req_ready_o = (state_q == IDLE) ? grant_onehot : '0;
    assign accept      = |(req_valid_i & req_ready_o);
    // A done level left high by the previous job must not complete this one.
    assign done_rise   = div_done_i & ~done_q;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    b_d     = req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    owner_d = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    result_d = div_result_i;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timeout_hit) begin
                    result_d = DATA_WIDTH'(FP32_QNAN);
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            done_q   <= div_done_i;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid_o = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_data_o  = (state_q == RESP) ? result_q : '0;
    assign rsp_err_o   = (state_q == RESP) & err_q;
    assign div_valid_o = (state_q == ISSUE);
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp32_div_scheduler.sv
// Bench for fp32_div_scheduler: behavioural divider model behind the scheduler,
// transaction-level expectation of grants, issue pulses and replies checked every cycle.
module tb_fp32_div_scheduler;
    import fp32_div_pkg::*;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            div_valid;
    logic [DW-1:0]   div_a, div_b, div_result;
    logic            div_done;
    logic            busy;
    sched_state_e    dbg_state;

    fp32_div_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .div_valid_o  (div_valid),
        .div_a_o      (div_a),
        .div_b_o      (div_b),
        .div_result_i (div_result),
        .div_done_i   (div_done),
        .busy_o       (busy),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Truncating FP32 divide for normal operands; also the divider model's datapath.
    function automatic logic [31:0] fp32_div(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] num;
        logic [24:0] q;
        logic [22:0] m;
        int          e;
        num = {1'b1, a[22:0], 24'd0};
        q   = 25'(num / {24'd0, 1'b1, b[22:0]});
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[24]) m = q[23:1];
        else begin
            m = q[22:0];
            e = e - 1;
        end
        return {a[31] ^ b[31], 8'(e), m};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(144, 110)), 23'($urandom)};
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
        end
        return '0;
    endfunction

    // ---------------- divider model ----------------
    int          dv_mode = 0;      // 0: normal, 1: never raises done
    int          dv_lat_min = 1, dv_lat_max = 6, dv_stale_max = 0;
    logic        dv_busy;
    int          dv_hold, dv_cnt;
    logic [31:0] dv_res;

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            div_done   <= 1'b0;
            div_result <= '0;
            dv_busy    <= 1'b0;
            dv_hold    <= 0;
            dv_cnt     <= 0;
            dv_res     <= '0;
        end else if (div_valid) begin
            dv_busy <= (dv_mode == 0);
            dv_hold <= int'($urandom_range(dv_stale_max, 0));
            dv_cnt  <= int'($urandom_range(dv_lat_max, dv_lat_min));
            dv_res  <= fp32_div(div_a, div_b);
            if (dv_mode == 1) div_done <= 1'b0;
        end else if (dv_busy) begin
            if (dv_hold > 0) dv_hold <= dv_hold - 1;
            else if (div_done) div_done <= 1'b0;
            else if (dv_cnt > 1) dv_cnt <= dv_cnt - 1;
            else begin
                div_done   <= 1'b1;
                div_result <= dv_res;
                dv_busy    <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [34:0] exp_q[$];         // {err, owner, data}
    int          cyc = 0, acc_cyc = -100, rise_cyc = -1, ptr_m = 0;
    logic [31:0] job_a, job_b;
    logic [N-1:0] hs_vec = '0;
    logic        prev_done = 1'b0;
    int          rsp_log[$];
    logic [31:0] last_data;
    logic        last_err;
    int          last_lat;

    always @(negedge clk) begin
        logic [34:0]  job;
        logic [N-1:0] exp_ready, exp_rv;
        logic         exp_busy, exp_rsp;
        int           idx;
        cyc++;
        if (!rstn_i) begin
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_data", 64'(rsp_data), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_div_valid", 64'(div_valid), 64'(0));
            exp_q.delete();
            ptr_m     = 0;
            hs_vec    = '0;
            prev_done = 1'b0;
        end else begin
            exp_busy  = (exp_q.size() != 0);
            exp_ready = exp_busy ? '0 : rr_pick(req_valid, ptr_m);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("ready", 64'(req_ready), 64'(exp_ready));
            chk("div_valid", 64'(div_valid), 64'(exp_busy && cyc == acc_cyc + 1));
            if (exp_busy && cyc == acc_cyc + 1) begin
                chk("div_a", 64'(div_a), 64'(job_a));
                chk("div_b", 64'(div_b), 64'(job_b));
            end
            exp_rsp = 1'b0;
            exp_rv  = '0;
            job     = '0;
            if (exp_busy) begin
                job = exp_q[0];
                if (div_done && !prev_done && cyc > acc_cyc + 1 && rise_cyc < 0) rise_cyc = cyc;
                exp_rsp = job[34] ? (cyc == acc_cyc + TIMEOUT + 2)
                                  : (rise_cyc >= 0 && cyc == rise_cyc + 1);
                if (exp_rsp) exp_rv = N'(1) << job[33:32];
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            chk("rsp_data", 64'(rsp_data), exp_rsp ? 64'(job[31:0]) : 64'(0));
            chk("rsp_err", 64'(rsp_err), 64'(exp_rsp & job[34]));
            if (rsp_valid != 0) begin
                for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) idx = i;
                rsp_log.push_back(idx);
                last_data = rsp_data;
                last_err  = rsp_err;
                last_lat  = cyc - acc_cyc;
            end
            if (exp_rsp) begin
                void'(exp_q.pop_front());
                ptr_m = (int'(job[33:32]) + 1) % N;
            end else if (exp_busy && cyc > acc_cyc + TIMEOUT + 8) begin
                total++;
                bad++;
                $display("FAIL no_response owner=%0d accepted_cycle=%0d", job[33:32], acc_cyc);
                exp_q.delete();
            end
            hs_vec = req_valid & req_ready;
            if (!exp_busy && (req_valid & exp_ready) != 0) begin
                for (int i = N - 1; i >= 0; i--) if (exp_ready[i]) idx = i;
                job_a = req_a[idx*DW +: DW];
                job_b = req_b[idx*DW +: DW];
                exp_q.push_back({dv_mode == 1, 2'(idx),
                                 (dv_mode == 1) ? FP32_QNAN : fp32_div(job_a, job_b)});
                acc_cyc  = cyc;
                rise_cyc = -1;
            end
            prev_done = div_done;
        end
    end

    // ---------------- driver tasks ----------------
    logic        fix_en = 1'b0;
    logic [31:0] fix_a, fix_b;

    task automatic step(input logic [N-1:0] new_mask, input logic [N-1:0] drop_mask);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_vec[i] || drop_mask[i]) req_valid[i] = 1'b0;
            if (new_mask[i] && !req_valid[i]) begin
                req_valid[i]      = 1'b1;
                req_a[i*DW +: DW] = fix_en ? fix_a : rand_fp();
                req_b[i*DW +: DW] = fix_en ? fix_b : rand_fp();
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || req_valid != 0) && n < 400) begin
            step('0, '0);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL wait_idle pending=%0d req_valid=%b", exp_q.size(), req_valid);
        end
    endtask

    task automatic do_reset();
        rstn_i    = 1'b0;
        req_valid = '0;
        step('0, '0);
        step('0, '0);
        rstn_i = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, "_div_valid"}, 64'(div_valid), 64'(0));
        chk({tag, "_div_a"}, 64'(div_a), 64'(0));
        chk({tag, "_div_b"}, 64'(div_b), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start, pos;
        rstn_i    = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        step('0, '0);
        step('0, '0);
        chk_all_zero("reset");
        chk("reset_state", 64'(dbg_state), 64'(IDLE));
        chk("model_10_div_5", 64'(fp32_div(32'h41200000, 32'h40A00000)), 64'h40000000);
        chk("model_1_div_2", 64'(fp32_div(32'h3F800000, 32'h40000000)), 64'h3F000000);
        rstn_i = 1'b1;

        // single job from requester 0
        fix_en = 1'b1;
        fix_a  = 32'h41200000;
        fix_b  = 32'h40A00000;
        rsp_log.delete();
        step(4'b0001, '0);
        wait_idle();
        chk("single_count", 64'(rsp_log.size()), 64'(1));
        chk("single_owner", 64'(rsp_log[0]), 64'(0));
        chk("single_data", 64'(last_data), 64'h40000000);
        chk("single_err", 64'(last_err), 64'(0));
        chk("single_busy_after", 64'(busy), 64'(0));

        // contention from a fresh pointer
        do_reset();
        fix_a = 32'h3F800000;
        fix_b = 32'h40000000;
        rsp_log.delete();
        step(4'b1111, '0);
        wait_idle();
        chk("cont_count", 64'(rsp_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), 64'(rsp_log[i]), 64'(i));
        chk("cont_data", 64'(last_data), 64'h3F000000);

        // fairness: requester 1 always asking, requester 2 asks once
        fix_en = 1'b0;
        rsp_log.delete();
        start = 0;
        for (int c = 0; c < 40; c++) begin
            step((c == 6) ? 4'b0110 : 4'b0010, '0);
            if (c == 6) start = rsp_log.size();
        end
        wait_idle();
        pos = -1;
        for (int j = rsp_log.size() - 1; j >= start; j--) if (rsp_log[j] == 2) pos = j;
        chk("fair_req2_within_2", 64'(pos >= start && pos - start < 2), 64'(1));

        // stale done level held across the next issue
        dv_stale_max = 3;
        dv_lat_max   = 3;
        for (int c = 0; c < 40; c++) step(4'b1000, '0);
        wait_idle();
        dv_stale_max = 0;
        dv_lat_max   = 6;

        // timeout with a divider that never finishes
        dv_mode = 1;
        fix_en  = 1'b1;
        fix_a   = 32'h40400000;
        fix_b   = 32'h3F800000;
        step(4'b0010, '0);
        wait_idle();
        chk("tmo_data", 64'(last_data), 64'h7FC00000);
        chk("tmo_err", 64'(last_err), 64'(1));
        chk("tmo_latency", 64'(last_lat), 64'(TIMEOUT + 2));
        dv_mode = 0;

        // reset while waiting on the divider
        dv_lat_min = 20;
        dv_lat_max = 20;
        rsp_log.delete();
        step(4'b0001, '0);
        for (int c = 0; c < 6; c++) step('0, '0);
        chk("midrst_busy_before", 64'(busy), 64'(1));
        #1;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        step('0, '0);
        step('0, '0);
        rstn_i     = 1'b1;
        dv_lat_min = 1;
        dv_lat_max = 6;
        chk("midrst_no_rsp", 64'(rsp_log.size()), 64'(0));
        fix_a = 32'h41200000;
        fix_b = 32'h40A00000;
        step(4'b0100, '0);
        wait_idle();
        chk("post_rst_owner", 64'(rsp_log.size() == 1 && rsp_log[0] == 2), 64'(1));
        chk("post_rst_data", 64'(last_data), 64'h40000000);

        // randomized traffic
        fix_en       = 1'b0;
        dv_stale_max = 2;
        for (int c = 0; c < 500; c++) begin
            logic [N-1:0] nm, dm;
            for (int i = 0; i < N; i++) begin
                nm[i] = ($urandom_range(2, 0) == 0);
                dm[i] = ($urandom_range(15, 0) == 0);
            end
            step(nm, dm);
        end
        wait_idle();
        chk("final_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
